// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - MMIO offsets, register select type and byte-lane merge helper.
package data_sram_responder_pkg;

    localparam logic [15:0] LED_OFS   = 16'h0000;
    localparam logic [15:0] SW_OFS    = 16'h0004;
    localparam logic [15:0] TIMER_OFS = 16'h0008;
    localparam logic [15:0] CMP_OFS   = 16'h000C;
    localparam logic [15:0] SCR_OFS   = 16'h0010;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_LED   = 3'd1,
        SEL_SW    = 3'd2,
        SEL_TIMER = 3'd3,
        SEL_CMP   = 3'd4,
        SEL_SCR   = 3'd5
    } mmio_sel_e;

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Word offset within the window; the byte bits [1:0] never take part in decode.
    function automatic mmio_sel_e decode_ofs(input logic [13:0] word_ofs);
        mmio_sel_e sel;
        if (word_ofs == LED_OFS[15:2]) begin
            sel = SEL_LED;
        end else if (word_ofs == SW_OFS[15:2]) begin
            sel = SEL_SW;
        end else if (word_ofs == TIMER_OFS[15:2]) begin
            sel = SEL_TIMER;
        end else if (word_ofs == CMP_OFS[15:2]) begin
            sel = SEL_CMP;
        end else if (word_ofs == SCR_OFS[15:2]) begin
            sel = SEL_SCR;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - Core data SRAM request/response bus.
interface data_sram_responder_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_responder_sram_byte_ram.sv
// rtl/data_sram_responder_sram_byte_ram.sv - Single-port read-first byte-enable RAM with registered output.
module data_sram_responder_sram_byte_ram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];
    logic [31:0] dout_d;
    logic [31:0] dout_q;

    // Contents survive reset; only the request is suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            dout_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign rdata = dout_q;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - Data SRAM responder: on-chip RAM plus LED/switch/timer/compare/scratch MMIO.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave bus,
    input  logic [7:0]           switch_in,
    output logic [15:0]          led_out,
    output logic                 timer_irq
);

    logic        mmio_hit;
    mmio_sel_e   sel;
    logic        req_wr;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rd;
    logic        unused_addr_bits;

    logic [15:0] led_d,        led_q;
    logic [31:0] timer_d,      timer_q;
    logic [31:0] cmp_d,        cmp_q;
    logic [31:0] scr_d,        scr_q;
    logic        irq_d,        irq_q;
    logic [31:0] mmio_rdata_d, mmio_rdata_q;
    logic        hit_sel_d,    hit_sel_q;

    assign unused_addr_bits = ^bus.sram_addr[1:0];

    always_comb begin
        mmio_hit = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
        sel      = mmio_hit ? decode_ofs(bus.sram_addr[15:2]) : SEL_NONE;
        req_wr   = bus.sram_en && (bus.sram_wen != 4'h0);
    end

    data_sram_responder_sram_byte_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.sram_en && !mmio_hit),
        .wen   (bus.sram_wen),
        .addr  (bus.sram_addr[RAM_AW+1:2]),
        .wdata (bus.sram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        led_d   = led_q;
        cmp_d   = cmp_q;
        scr_d   = scr_q;
        timer_d = timer_q + 32'd1;
        irq_d   = irq_q;
        if (req_wr) begin
            case (sel)
                SEL_LED: begin
                    if (bus.sram_wen[0]) led_d[7:0]  = bus.sram_wdata[7:0];
                    if (bus.sram_wen[1]) led_d[15:8] = bus.sram_wdata[15:8];
                end
                SEL_TIMER: timer_d = lane_merge(timer_q, bus.sram_wdata, bus.sram_wen);
                SEL_CMP:   cmp_d   = lane_merge(cmp_q, bus.sram_wdata, bus.sram_wen);
                SEL_SCR:   scr_d   = lane_merge(scr_q, bus.sram_wdata, bus.sram_wen);
                default:   ;
            endcase
        end
        // Match uses pre-increment count and current compare; a compare write clears and wins.
        if ((timer_q == cmp_q) && (cmp_q != 32'd0)) begin
            irq_d = 1'b1;
        end
        if (req_wr && (sel == SEL_CMP)) begin
            irq_d = 1'b0;
        end
    end

    always_comb begin
        case (sel)
            SEL_LED:   mmio_rd = {16'h0000, led_q};
            SEL_SW:    mmio_rd = {24'h00_0000, switch_in};
            SEL_TIMER: mmio_rd = timer_q;
            SEL_CMP:   mmio_rd = cmp_q;
            SEL_SCR:   mmio_rd = scr_q;
            default:   mmio_rd = 32'h0000_0000;
        endcase
        mmio_rdata_d = mmio_rdata_q;
        hit_sel_d    = hit_sel_q;
        if (bus.sram_en) begin
            hit_sel_d = mmio_hit;
            if (mmio_hit) begin
                mmio_rdata_d = mmio_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            timer_q      <= '0;
            cmp_q        <= '0;
            scr_q        <= '0;
            irq_q        <= 1'b0;
            mmio_rdata_q <= '0;
            hit_sel_q    <= 1'b0;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            cmp_q        <= cmp_d;
            scr_q        <= scr_d;
            irq_q        <= irq_d;
            mmio_rdata_q <= mmio_rdata_d;
            hit_sel_q    <= hit_sel_d;
        end
    end

    // Both sources are already registered; only the select was captured with the request.
    assign bus.sram_rdata = hit_sel_q ? mmio_rdata_q : ram_rdata;
    assign led_out        = led_q;
    assign timer_irq      = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - Self-checking bench for data_sram_responder against a behavioural model.
module tb_data_sram_responder;

    localparam int          RAM_AW = 14;
    localparam logic [31:0] MB     = 32'hBFAF_0000;

    logic        clk;
    logic        rst;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic        timer_irq;

    data_sram_responder_if bus();

    data_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ram [int unsigned];
    logic [31:0] m_rdata;
    logic [31:0] m_timer;
    logic [31:0] m_cmp;
    logic [31:0] m_scr;
    logic [15:0] m_led;
    logic        m_irq;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // One clock: drive at the falling edge, update the model at the rising edge, return at the next falling edge.
    task automatic step(input logic r, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] t_old, c_old, rd, tmp;
        logic        t_wr, c_wr;
        int unsigned idx;
        rst            = r;
        bus.sram_en    = en;
        bus.sram_wen   = wen;
        bus.sram_addr  = addr;
        bus.sram_wdata = wdata;
        @(posedge clk);
        if (r) begin
            m_rdata = 0; m_led = 0; m_timer = 0; m_cmp = 0; m_scr = 0; m_irq = 0;
        end else begin
            t_old = m_timer; c_old = m_cmp; t_wr = 0; c_wr = 0;
            if (en) begin
                if (addr[31:16] != MB[31:16]) begin
                    idx = (addr >> 2) & ((32'd1 << RAM_AW) - 1);
                    rd  = m_ram.exists(idx) ? m_ram[idx] : 32'hx;
                    m_ram[idx] = merge(rd, wdata, wen);
                end else begin
                    case ({addr[15:2], 2'b00})
                        16'h0000: begin rd = {16'h0, m_led}; tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
                        16'h0004: rd = {24'h0, switch_in};
                        16'h0008: begin rd = t_old; if (wen != 0) begin t_wr = 1; m_timer = merge(t_old, wdata, wen); end end
                        16'h000C: begin rd = c_old; m_cmp = merge(c_old, wdata, wen); c_wr = (wen != 0); end
                        16'h0010: begin rd = m_scr; m_scr = merge(m_scr, wdata, wen); end
                        default:  rd = 0;
                    endcase
                end
                m_rdata = rd;
            end
            if (!t_wr) m_timer = t_old + 1;
            if (t_old == c_old && c_old != 0) m_irq = 1;
            if (c_wr) m_irq = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        repeat (3) step(1, 0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.sram_rdata); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led got=%h exp=0", led_out); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    endtask

    task automatic test_write_read();
        step(0, 1, 4'hF, 32'h0000_0100, 32'h1234_5678);
        step(0, 1, 4'h0, 32'h0000_0100, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL write_read got=%h exp=12345678", bus.sram_rdata); end
        idle();
        checks++; if (bus.sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL hold_en0 got=%h exp=12345678", bus.sram_rdata); end
        step(0, 1, 4'h0, 32'h0001_0100, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL alias_bit16 got=%h exp=12345678", bus.sram_rdata); end
        step(0, 1, 4'h0, 32'h7FFC_0102, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL alias_high got=%h exp=12345678", bus.sram_rdata); end
    endtask

    task automatic test_partial_write();
        step(0, 1, 4'hF, 32'h0000_0200, 32'hAABB_CCDD);
        step(0, 1, 4'h2, 32'h0000_0200, 32'h0000_EE00);
        step(0, 1, 4'h0, 32'h0000_0200, 32'h0);
        checks++; if (bus.sram_rdata !== 32'hAABB_EEDD) begin errors++; $display("FAIL partial_write got=%h exp=AABBEEDD", bus.sram_rdata); end
    endtask

    task automatic test_read_first();
        step(0, 1, 4'hF, 32'h0000_0300, 32'd5);
        step(0, 1, 4'hF, 32'h0000_0300, 32'd7);
        checks++; if (bus.sram_rdata !== 32'd5) begin errors++; $display("FAIL read_first_old got=%h exp=5", bus.sram_rdata); end
        step(0, 1, 4'h0, 32'h0000_0300, 32'h0);
        checks++; if (bus.sram_rdata !== 32'd7) begin errors++; $display("FAIL read_first_new got=%h exp=7", bus.sram_rdata); end
    endtask

    task automatic test_led_switch();
        step(0, 1, 4'hF, MB | 32'h0, 32'hFFFF_A5A5);
        checks++; if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_out got=%h exp=A5A5", led_out); end
        step(0, 1, 4'h0, MB | 32'h0, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h0000_A5A5) begin errors++; $display("FAIL led_read got=%h exp=0000A5A5", bus.sram_rdata); end
        step(0, 1, 4'h2, MB | 32'h0, 32'h0000_1100);
        checks++; if (led_out !== 16'h11A5) begin errors++; $display("FAIL led_lane got=%h exp=11A5", led_out); end
        switch_in = 8'h3C;
        step(0, 1, 4'hF, MB | 32'h4, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, MB | 32'h4, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h0000_003C) begin errors++; $display("FAIL switch_read got=%h exp=0000003C", bus.sram_rdata); end
        step(0, 1, 4'hF, MB | 32'h10, 32'hDEAD_BEEF);
        step(0, 1, 4'hF, MB | 32'h14, 32'h1111_1111);
        step(0, 1, 4'h0, MB | 32'h10, 32'h0);
        checks++; if (bus.sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_read got=%h exp=DEADBEEF", bus.sram_rdata); end
        step(0, 1, 4'h0, MB | 32'h14, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", bus.sram_rdata); end
    endtask

    task automatic test_timer_irq();
        step(0, 1, 4'hF, MB | 32'h8, 32'hFFFF_FFFE);
        step(0, 1, 4'hF, MB | 32'hC, 32'h0000_0003);
        step(0, 1, 4'h0, MB | 32'h8, 32'h0);
        checks++; if (bus.sram_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_read got=%h exp=FFFFFFFF", bus.sram_rdata); end
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++; if (timer_irq !== (i == 3)) begin errors++; $display("FAIL irq_rise_%0d got=%b exp=%b", i, timer_irq, (i == 3)); end
        end
        step(0, 1, 4'h0, MB | 32'h8, 32'h0);
        checks++; if (bus.sram_rdata !== 32'd4) begin errors++; $display("FAIL timer_wrapped got=%h exp=4", bus.sram_rdata); end
        repeat (3) idle();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_sticky got=%b exp=1", timer_irq); end
        step(0, 1, 4'h1, MB | 32'hC, 32'h0);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    endtask

    task automatic test_clear_coincide();
        step(0, 1, 4'hF, MB | 32'hC, 32'd20);
        step(0, 1, 4'hF, MB | 32'h8, 32'd18);
        repeat (3) idle();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_match20 got=%b exp=1", timer_irq); end
        step(0, 1, 4'hF, MB | 32'h8, 32'd19);
        idle();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_before_clear got=%b exp=1", timer_irq); end
        step(0, 1, 4'hF, MB | 32'hC, 32'd20);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL clear_wins got=%b exp=0", timer_irq); end
        idle();
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL clear_stays got=%b exp=0", timer_irq); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 4'hF, 32'h0000_0400, 32'hCAFE_F00D);
        step(0, 1, 4'hF, MB | 32'h0, 32'h0000_1234);
        step(0, 1, 4'hF, MB | 32'hC, 32'd5);
        step(0, 1, 4'hF, MB | 32'h8, 32'd3);
        repeat (3) idle();
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", timer_irq); end
        step(0, 1, 4'h0, 32'h0000_0400, 32'h0);
        checks++; if (bus.sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL pre_reset_read got=%h exp=CAFEF00D", bus.sram_rdata); end
        step(1, 1, 4'h0, 32'h0000_0400, 32'h0);
        checks++; if (bus.sram_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rdata got=%h exp=0", bus.sram_rdata); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%b exp=0", timer_irq); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL mid_reset_led got=%h exp=0", led_out); end
        idle();
        checks++; if (bus.sram_rdata !== 32'h0) begin errors++; $display("FAIL post_reset_hold got=%h exp=0", bus.sram_rdata); end
        step(0, 1, 4'h0, 32'h0000_0400, 32'h0);
        checks++; if (bus.sram_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_kept got=%h exp=CAFEF00D", bus.sram_rdata); end
        step(0, 1, 4'h0, MB | 32'h8, 32'h0);
        checks++; if (bus.sram_rdata !== m_rdata) begin errors++; $display("FAIL timer_after_reset got=%h exp=%h", bus.sram_rdata, m_rdata); end
    endtask

    task automatic test_random();
        logic [13:0] ridx [8];
        logic [15:0] ofs_tab [7];
        logic [15:0] up;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic        en;
        int          kind;
        ofs_tab = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0100};
        for (int k = 0; k < 8; k++) begin
            ridx[k] = 14'($urandom);
            step(0, 1, 4'hF, {16'h0000, ridx[k], 2'b00}, $urandom);
        end
        for (int n = 0; n < 300; n++) begin
            switch_in = 8'($urandom);
            en   = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            if (kind < 2) begin
                up = 16'($urandom);
                if (up == MB[31:16]) up = 16'h0;
                addr = {up, ridx[$urandom_range(0, 7)], 2'($urandom)};
            end else begin
                addr = {MB[31:16], ofs_tab[$urandom_range(0, 6)]};
                addr[1:0] = 2'($urandom);
            end
            wen = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            step(0, en, wen, addr, $urandom);
            checks++; if (bus.sram_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, bus.sram_rdata, m_rdata); end
            checks++; if (led_out !== m_led) begin errors++; $display("FAIL rand_led n=%0d got=%h exp=%h", n, led_out, m_led); end
            checks++; if (timer_irq !== m_irq) begin errors++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, timer_irq, m_irq); end
        end
    endtask

    initial begin
        rst            = 1'b1;
        switch_in      = 8'h00;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_read_first();
        test_led_switch();
        test_timer_irq();
        test_clear_coincide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
